// File: rtl/viterbi_pkg.sv
// rtl/viterbi_pkg.sv - shared constants and helpers for the Viterbi decoder datapath
//
// Purpose : width derivation, soft-symbol range and branch-label helpers used by
//           the branch metric unit and the ACS array. No ports.
// Macros  : VIT_METRIC_GET(vec, idx, w) - select metric idx of width w from a
//           packed metric vector (usable as lvalue or rvalue).
`ifndef VITERBI_PKG_SV
`define VITERBI_PKG_SV

`define VIT_METRIC_GET(vec, idx, w) vec[(idx)*(w) +: (w)]

package viterbi_pkg;

  // Ceiling log2; clog2(1) = 0.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

  // Largest soft symbol value: 0 = confident '0', max = confident '1'.
  function automatic int max_soft(input int soft_w);
    return (1 << soft_w) - 1;
  endfunction

  // Width of one branch metric: worst case is every symbol at full distance.
  function automatic int bm_width(input int n_out, input int soft_w);
    return clog2(n_out * max_soft(soft_w) + 1);
  endfunction

  // Bit bit_idx of a branch label; label bit i pairs with received symbol i.
  function automatic logic label_bit(input int label, input int bit_idx);
    return ((label >> bit_idx) & 1) != 0;
  endfunction

endpackage

`endif

// File: rtl/bmu_min_tree.sv
// rtl/bmu_min_tree.sv - combinational min/argmin reduction tree
//
// Purpose : finds the smallest of COUNT unsigned values and its index. On a tie
//           the lower index wins.
// Ports   : vals_i [COUNT*WIDTH] value k at [k*WIDTH +: WIDTH]
//           min_o  [WIDTH]       smallest value
//           idx_o  [IDX_W]       lowest index holding min_o
module bmu_min_tree
  import viterbi_pkg::*;
#(
  parameter int COUNT = 4,
  parameter int WIDTH = 2,
  parameter int IDX_W = 2
) (
  input  logic [COUNT*WIDTH-1:0] vals_i,
  output logic [WIDTH-1:0]       min_o,
  output logic [IDX_W-1:0]       idx_o
);

  localparam int LEVELS = clog2(COUNT);
  localparam int POW    = 1 << LEVELS;

  // Level 0 holds the leaves (padded to a power of two with invalid entries);
  // each following level halves the node count until one node remains.
  for (genvar l = 0; l <= LEVELS; l++) begin : g_lvl
    localparam int N = POW >> l;
    logic [WIDTH-1:0] val [N];
    logic [IDX_W-1:0] idx [N];
    logic             vld [N];

    if (l == 0) begin : g_leaf
      for (genvar j = 0; j < N; j++) begin : g_j
        if (j < COUNT) begin : g_real
          assign val[j] = vals_i[j*WIDTH +: WIDTH];
          assign idx[j] = IDX_W'(j);
          assign vld[j] = 1'b1;
        end else begin : g_pad
          assign val[j] = '0;
          assign idx[j] = '0;
          assign vld[j] = 1'b0;
        end
      end
    end else begin : g_node
      for (genvar j = 0; j < N; j++) begin : g_j
        logic take_hi;
        // The low child always covers lower indices, so the high child only
        // wins when strictly smaller; that gives the lower-index tie-break.
        assign take_hi = g_lvl[l-1].vld[2*j+1] &&
                         (!g_lvl[l-1].vld[2*j] ||
                          (g_lvl[l-1].val[2*j+1] < g_lvl[l-1].val[2*j]));
        assign val[j] = take_hi ? g_lvl[l-1].val[2*j+1] : g_lvl[l-1].val[2*j];
        assign idx[j] = take_hi ? g_lvl[l-1].idx[2*j+1] : g_lvl[l-1].idx[2*j];
        assign vld[j] = g_lvl[l-1].vld[2*j] | g_lvl[l-1].vld[2*j+1];
      end
    end
  end

  assign min_o = g_lvl[LEVELS].val[0];
  assign idx_o = g_lvl[LEVELS].idx[0];

endmodule

// File: rtl/branch_metric_unit.sv
// rtl/branch_metric_unit.sv - pipelined branch metric unit for the Viterbi decoder
//
// Purpose : for each received group of N_OUT symbols, computes the metric of all
//           2^N_OUT branch labels plus the minimum metric and its lowest label.
//           Two register stages (S1: per-symbol distances, S2: sums + min) with
//           valid/ready flow control on both sides.
// Option  : BMU_ERASURE_EN adds erase_mask; an erased symbol contributes 0.
// Ports   : clk, rst_n (async, active low)
//           in_valid / in_ready / data_recv [N_OUT*SOFT_W]  symbol i at [i*SOFT_W +: SOFT_W]
//           erase_mask [N_OUT]                              (BMU_ERASURE_EN only)
//           out_valid / out_ready
//           bm_all [2^N_OUT*BM_W]  metric of label p at [p*BM_W +: BM_W]
//           bm_min [BM_W], bm_min_idx [N_OUT]
module branch_metric_unit
  import viterbi_pkg::*;
#(
  parameter int N_OUT  = 2,
  parameter int SOFT_W = 1
) (
  input  logic                                           clk,
  input  logic                                           rst_n,
  input  logic                                           in_valid,
  output logic                                           in_ready,
  input  logic [N_OUT*SOFT_W-1:0]                        data_recv,
`ifdef BMU_ERASURE_EN
  input  logic [N_OUT-1:0]                               erase_mask,
`endif
  output logic                                           out_valid,
  input  logic                                           out_ready,
  output logic [(2**N_OUT)*bm_width(N_OUT, SOFT_W)-1:0]  bm_all,
  output logic [bm_width(N_OUT, SOFT_W)-1:0]             bm_min,
  output logic [N_OUT-1:0]                               bm_min_idx
);

  localparam int BM_W  = bm_width(N_OUT, SOFT_W);
  localparam int N_LBL = 2**N_OUT;
  localparam logic [SOFT_W-1:0] MAX_S = SOFT_W'(max_soft(SOFT_W));

  // Stage S1 state
  logic                          s1_valid_q, s1_valid_d;
  logic [N_OUT-1:0][SOFT_W-1:0]  d0_q, d0_d;
  logic [N_OUT-1:0][SOFT_W-1:0]  d1_q, d1_d;

  // Stage S2 state
  logic                          s2_valid_q, s2_valid_d;
  logic [N_LBL*BM_W-1:0]         bm_all_q, bm_all_d;
  logic [BM_W-1:0]               bm_min_q, bm_min_d;
  logic [N_OUT-1:0]              bm_min_idx_q, bm_min_idx_d;

  // Combinational datapath
  logic [N_OUT-1:0][SOFT_W-1:0]  d0_sym, d1_sym;
  logic [N_LBL*BM_W-1:0]         sum_flat;
  logic [BM_W-1:0]               tree_min;
  logic [N_OUT-1:0]              tree_idx;

  // Handshake
  logic s2_load;
  logic s1_move;
  logic in_acc;

  assign s2_load  = !s2_valid_q || out_ready;
  assign s1_move  = s1_valid_q && s2_load;
  assign in_ready = !s1_valid_q || s2_load;
  assign in_acc   = in_valid && in_ready;

  // Per-symbol distance to a '0' label bit and to a '1' label bit.
  always_comb begin
    d0_sym = '0;
    d1_sym = '0;
    for (int i = 0; i < N_OUT; i++) begin
      d0_sym[i] = data_recv[i*SOFT_W +: SOFT_W];
      d1_sym[i] = MAX_S - data_recv[i*SOFT_W +: SOFT_W];
`ifdef BMU_ERASURE_EN
      if (erase_mask[i]) begin
        d0_sym[i] = '0;
        d1_sym[i] = '0;
      end
`endif
    end
  end

  // Label sums from the S1 distances.
  always_comb begin
    sum_flat = '0;
    for (int p = 0; p < N_LBL; p++) begin
      for (int i = 0; i < N_OUT; i++) begin
        `VIT_METRIC_GET(sum_flat, p, BM_W) = `VIT_METRIC_GET(sum_flat, p, BM_W) +
            BM_W'(label_bit(p, i) ? d1_q[i] : d0_q[i]);
      end
    end
  end

  bmu_min_tree #(
    .COUNT (N_LBL),
    .WIDTH (BM_W),
    .IDX_W (N_OUT)
  ) u_min_tree (
    .vals_i (sum_flat),
    .min_o  (tree_min),
    .idx_o  (tree_idx)
  );

  // Next-state: S1 refills whenever it is free (or draining) and takes the
  // handshake result as its new valid; S2 likewise follows S1.
  always_comb begin
    s1_valid_d   = s1_valid_q;
    d0_d         = d0_q;
    d1_d         = d1_q;
    s2_valid_d   = s2_valid_q;
    bm_all_d     = bm_all_q;
    bm_min_d     = bm_min_q;
    bm_min_idx_d = bm_min_idx_q;

    if (in_ready) begin
      s1_valid_d = in_valid;
    end
    if (in_acc) begin
      d0_d = d0_sym;
      d1_d = d1_sym;
    end

    if (s2_load) begin
      s2_valid_d = s1_valid_q;
    end
    if (s1_move) begin
      bm_all_d     = sum_flat;
      bm_min_d     = tree_min;
      bm_min_idx_d = tree_idx;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q   <= 1'b0;
      d0_q         <= '0;
      d1_q         <= '0;
      s2_valid_q   <= 1'b0;
      bm_all_q     <= '0;
      bm_min_q     <= '0;
      bm_min_idx_q <= '0;
    end else begin
      s1_valid_q   <= s1_valid_d;
      d0_q         <= d0_d;
      d1_q         <= d1_d;
      s2_valid_q   <= s2_valid_d;
      bm_all_q     <= bm_all_d;
      bm_min_q     <= bm_min_d;
      bm_min_idx_q <= bm_min_idx_d;
    end
  end

  assign out_valid  = s2_valid_q;
  assign bm_all     = bm_all_q;
  assign bm_min     = bm_min_q;
  assign bm_min_idx = bm_min_idx_q;

endmodule

// File: tb/tb_branch_metric_unit.sv
// tb/tb_branch_metric_unit.sv - self-checking bench for branch_metric_unit
module tb_branch_metric_unit;
  import viterbi_pkg::*;

  localparam int A_N  = 2;
  localparam int A_S  = 1;
  localparam int A_BM = bm_width(A_N, A_S);
  localparam int B_N  = 3;
  localparam int B_S  = 3;
  localparam int B_BM = bm_width(B_N, B_S);

  logic clk;
  logic rst_n;

  logic                      a_in_valid, a_in_ready, a_out_valid, a_out_ready;
  logic [A_N*A_S-1:0]        a_data;
  logic [A_N-1:0]            a_mask;
  logic [(2**A_N)*A_BM-1:0]  a_bm_all;
  logic [A_BM-1:0]           a_bm_min;
  logic [A_N-1:0]            a_bm_idx;

  logic                      b_in_valid, b_in_ready, b_out_valid, b_out_ready;
  logic [B_N*B_S-1:0]        b_data;
  logic [B_N-1:0]            b_mask;
  logic [(2**B_N)*B_BM-1:0]  b_bm_all;
  logic [B_BM-1:0]           b_bm_min;
  logic [B_N-1:0]            b_bm_idx;

  branch_metric_unit #(.N_OUT(A_N), .SOFT_W(A_S)) u_hard (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (a_in_valid),
    .in_ready   (a_in_ready),
    .data_recv  (a_data),
`ifdef BMU_ERASURE_EN
    .erase_mask (a_mask),
`endif
    .out_valid  (a_out_valid),
    .out_ready  (a_out_ready),
    .bm_all     (a_bm_all),
    .bm_min     (a_bm_min),
    .bm_min_idx (a_bm_idx)
  );

  branch_metric_unit #(.N_OUT(B_N), .SOFT_W(B_S)) u_soft (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (b_in_valid),
    .in_ready   (b_in_ready),
    .data_recv  (b_data),
`ifdef BMU_ERASURE_EN
    .erase_mask (b_mask),
`endif
    .out_valid  (b_out_valid),
    .out_ready  (b_out_ready),
    .bm_all     (b_bm_all),
    .bm_min     (b_bm_min),
    .bm_min_idx (b_bm_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  int exp_m [16];
  int exp_min;
  int exp_idx;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: metric of label p = sum of |label bit value - symbol| over the
  // non-erased symbols, then a plain linear scan for the first minimum.
  task automatic model(input int n, input int sw, input int data, input int mask);
    int maxv;
    int s;
    maxv = (1 << sw) - 1;
    for (int p = 0; p < (1 << n); p++) begin
      exp_m[p] = 0;
      for (int i = 0; i < n; i++) begin
        if (((mask >> i) & 1) == 0) begin
          s = (data >> (i * sw)) & maxv;
          exp_m[p] += (((p >> i) & 1) == 1) ? (maxv - s) : s;
        end
      end
    end
    exp_min = exp_m[0];
    exp_idx = 0;
    for (int p = 1; p < (1 << n); p++) begin
      if (exp_m[p] < exp_min) begin
        exp_min = exp_m[p];
        exp_idx = p;
      end
    end
  endtask

  function automatic logic [63:0] pack_model(input int n, input int w);
    logic [63:0] v;
    v = '0;
    for (int p = 0; p < (1 << n); p++) v = v | (64'(exp_m[p]) << (p * w));
    return v;
  endfunction

  // One group into the soft unit with out_ready high; checks latency and result.
  task automatic send_b(input logic [B_N*B_S-1:0] d, input logic [B_N-1:0] m, input string tag);
    @(negedge clk);
    b_in_valid = 1'b1;
    b_data     = d;
    b_mask     = m;
    #1 check({tag, "_in_ready"}, 64'(b_in_ready), 64'(1));
    @(negedge clk);
    b_in_valid = 1'b0;
    #1 check({tag, "_lat1_valid"}, 64'(b_out_valid), 64'(0));
    @(negedge clk);
    #1 check({tag, "_lat2_valid"}, 64'(b_out_valid), 64'(1));
`ifdef BMU_ERASURE_EN
    model(B_N, B_S, int'(d), int'(m));
`else
    model(B_N, B_S, int'(d), 0);
`endif
    check({tag, "_bm_all"}, 64'(b_bm_all), pack_model(B_N, B_BM));
    check({tag, "_bm_min"}, 64'(b_bm_min), 64'(exp_min));
    check({tag, "_bm_idx"}, 64'(b_bm_idx), 64'(exp_idx));
  endtask

  typedef struct {
    logic [1:0] data;
    logic [7:0] bm;
    int         mn;
    int         idx;
  } hvec_t;

  typedef struct {
    logic [8:0] data;
    int         mn;
    int         idx;
    int         lbl;
    int         lbl_m;
  } svec_t;

  hvec_t htab [4];
  svec_t stab [4];

  logic [63:0] q_all [$];
  int          q_min [$];
  int          q_idx [$];

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : main
    int          sent;
    int          recv;
    int          cyc;
    logic        stalled_prev;
    logic [63:0] hold_all;
    logic [63:0] hold_min;
    logic [63:0] hold_idx;

    // Hamming golden values, labels packed {p3,p2,p1,p0}, 2 bits each.
    htab[0] = '{2'b00, 8'h94, 0, 0};
    htab[1] = '{2'b01, 8'h61, 0, 1};
    htab[2] = '{2'b10, 8'h49, 0, 2};
    htab[3] = '{2'b11, 8'h16, 0, 3};
    // Soft vectors {s2,s1,s0}; lbl/lbl_m single out one label's metric.
    stab[0] = '{9'h1C3, 3, 4, 3, 18};
    stab[1] = '{9'h024, 6, 3, 0, 8};
    stab[2] = '{9'h1FF, 0, 7, 0, 21};
    stab[3] = '{9'h000, 0, 0, 7, 21};

    rst_n       = 1'b0;
    a_in_valid  = 1'b0;
    a_data      = '0;
    a_mask      = '0;
    a_out_ready = 1'b1;
    b_in_valid  = 1'b0;
    b_data      = '0;
    b_mask      = '0;
    b_out_ready = 1'b1;

    repeat (3) @(negedge clk);
    #1;
    check("rst_a_out_valid", 64'(a_out_valid), 64'(0));
    check("rst_a_bm_all",    64'(a_bm_all),    64'(0));
    check("rst_b_out_valid", 64'(b_out_valid), 64'(0));
    check("rst_b_bm_all",    64'(b_bm_all),    64'(0));
    check("rst_b_bm_min",    64'(b_bm_min),    64'(0));
    check("rst_b_bm_idx",    64'(b_bm_idx),    64'(0));

    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("post_rst_a_in_ready", 64'(a_in_ready), 64'(1));
    check("post_rst_b_in_ready", 64'(b_in_ready), 64'(1));

    // Hard decision sweep, one group per cycle, result two cycles later.
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      a_in_valid = (c < 4);
      a_data     = 2'(c);
      #1;
      check($sformatf("hard_valid_c%0d", c), 64'(a_out_valid), 64'(c >= 2));
      if (c >= 2) begin
        check($sformatf("hard_bm_all_%0d", c - 2), 64'(a_bm_all), 64'(htab[c-2].bm));
        check($sformatf("hard_bm_min_%0d", c - 2), 64'(a_bm_min), 64'(htab[c-2].mn));
        check($sformatf("hard_bm_idx_%0d", c - 2), 64'(a_bm_idx), 64'(htab[c-2].idx));
      end
    end
    a_in_valid = 1'b0;

    // Soft table vectors.
    for (int k = 0; k < 4; k++) begin
      send_b(stab[k].data, '0, $sformatf("soft%0d", k));
      check($sformatf("soft%0d_tab_min", k), 64'(b_bm_min), 64'(stab[k].mn));
      check($sformatf("soft%0d_tab_idx", k), 64'(b_bm_idx), 64'(stab[k].idx));
      check($sformatf("soft%0d_tab_lbl", k),
            64'(b_bm_all[stab[k].lbl*B_BM +: B_BM]), 64'(stab[k].lbl_m));
    end

    // Backpressure: 10 random groups, out_ready low for the first 5 cycles.
    sent = 0;
    recv = 0;
    cyc  = 0;
    stalled_prev = 1'b0;
    hold_all = '0;
    hold_min = '0;
    hold_idx = '0;
    while (recv < 10 && cyc < 500) begin
      @(negedge clk);
      b_out_ready = (cyc < 5) ? 1'b0 : 1'($urandom_range(0, 1));
      if (sent < 10) begin
        b_in_valid = (cyc < 5) ? 1'b1 : ($urandom_range(0, 3) != 0);
        b_data     = 9'($urandom);
`ifdef BMU_ERASURE_EN
        b_mask     = 3'($urandom);
`endif
      end else begin
        b_in_valid = 1'b0;
      end
      #1;
      if (cyc < 5) check($sformatf("bp_in_ready_c%0d", cyc), 64'(b_in_ready), 64'(cyc < 2));
      if (stalled_prev) begin
        check("bp_stall_valid", 64'(b_out_valid), 64'(1));
        check("bp_stall_all",   64'(b_bm_all),    hold_all);
        check("bp_stall_min",   64'(b_bm_min),    hold_min);
        check("bp_stall_idx",   64'(b_bm_idx),    hold_idx);
      end
      if (b_in_valid && b_in_ready) begin
        model(B_N, B_S, int'(b_data), int'(b_mask));
        q_all.push_back(pack_model(B_N, B_BM));
        q_min.push_back(exp_min);
        q_idx.push_back(exp_idx);
        sent++;
      end
      if (b_out_valid && b_out_ready) begin
        if (q_all.size() == 0) begin
          check("bp_unexpected_output", 64'(1), 64'(0));
        end else begin
          check($sformatf("bp_all_%0d", recv), 64'(b_bm_all), q_all.pop_front());
          check($sformatf("bp_min_%0d", recv), 64'(b_bm_min), 64'(q_min.pop_front()));
          check($sformatf("bp_idx_%0d", recv), 64'(b_bm_idx), 64'(q_idx.pop_front()));
        end
        recv++;
      end
      stalled_prev = b_out_valid && !b_out_ready;
      hold_all = 64'(b_bm_all);
      hold_min = 64'(b_bm_min);
      hold_idx = 64'(b_bm_idx);
      cyc++;
    end
    b_in_valid  = 1'b0;
    b_out_ready = 1'b1;
    check("bp_delivered", 64'(recv), 64'(10));
    check("bp_queue_left", 64'(q_all.size()), 64'(0));
    repeat (2) @(negedge clk);
    #1 check("bp_no_extra", 64'(b_out_valid), 64'(0));

    // Reset with two groups in flight.
    @(negedge clk);
    b_out_ready = 1'b0;
    b_in_valid  = 1'b1;
    b_data      = 9'h0A5;
    b_mask      = '0;
    @(negedge clk);
    b_data = 9'h15A;
    @(negedge clk);
    b_in_valid = 1'b0;
    #1;
    check("mid_full_valid", 64'(b_out_valid), 64'(1));
    check("mid_full_in_ready", 64'(b_in_ready), 64'(0));
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_valid",  64'(b_out_valid), 64'(0));
    check("mid_rst_bm_all", 64'(b_bm_all),    64'(0));
    check("mid_rst_bm_min", 64'(b_bm_min),    64'(0));
    repeat (2) @(negedge clk);
    rst_n       = 1'b1;
    b_out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      #1 check($sformatf("mid_no_stale_%0d", k), 64'(b_out_valid), 64'(0));
    end
    send_b(9'h0F3, '0, "after_rst");

`ifdef BMU_ERASURE_EN
    // Hard unit, symbol 0 erased: only label bit 1 matters.
    @(negedge clk);
    a_in_valid = 1'b1;
    a_data     = 2'b11;
    a_mask     = 2'b01;
    @(negedge clk);
    a_in_valid = 1'b0;
    @(negedge clk);
    #1;
    model(A_N, A_S, 3, 1);
    check("era_a_valid",  64'(a_out_valid), 64'(1));
    check("era_a_bm_all", 64'(a_bm_all),    pack_model(A_N, A_BM));
    check("era_a_bm_idx", 64'(a_bm_idx),    64'(2));
    a_mask = '0;
    // Everything erased: all metrics zero, lowest label wins.
    send_b(9'h1C3, 3'b111, "era_all");
    check("era_all_bm_all", 64'(b_bm_all), 64'(0));
    check("era_all_bm_idx", 64'(b_bm_idx), 64'(0));
    // Partial erasure creating ties at the minimum.
    send_b(9'h1C3, 3'b100, "era_tie");
`endif

    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
